// File: rtl/codon_pattern_loader.sv
// Pattern sequencer for the codon counter: fetches each pattern from the ROM,
// pulses the counter clear, holds count enable until done_gen, repeats per pattern.
module codon_pattern_loader #(
  parameter int NUM_PAT = 6,
  parameter int PAT_LEN = 6,
  parameter int PAT_AW  = 6,
  parameter int TIMEOUT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        spo_pat,
  output logic [PAT_AW-1:0] addr_pat,
  output logic [5:0][3:0]   data,
  output logic              init_cnt_ena,
  output logic              count_ena,
  input  logic              done_gen,
  output logic              busy,
  output logic [2:0]        pat_idx,
  output logic              all_done,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    INIT  = 3'd2,
    COUNT = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      nib;
  logic            seen_f;
  logic [WD_W-1:0] wdog;
  logic            empty_pat;
  logic            last_nib;
  logic            last_pat;
  logic            wd_expired;
  logic            timeout_hit;
  logic            start_ok;

  assign empty_pat  = (nib == 3'd0) && (spo_pat == 4'hF);
  assign last_nib   = (nib == 3'(PAT_LEN - 1));
  assign last_pat   = (pat_idx == 3'(NUM_PAT - 1));
  assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // abort overrides every transition, including a timeout in the same cycle
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: begin
        if (empty_pat)     state_next = DONE;
        else if (last_nib) state_next = INIT;
      end
      INIT:  state_next = COUNT;
      COUNT: begin
        if (done_gen) begin
          state_next = NEXT;
        end else if (wd_expired) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      NEXT:    state_next = last_pat ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next  = IDLE;
      timeout_hit = 1'b0;
    end
  end

  assign start_ok = (state == IDLE) && (state_next == FETCH);

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt_ena <= 1'b0;
      count_ena    <= 1'b0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
    end else begin
      init_cnt_ena <= (state_next == INIT);
      count_ena    <= (state_next == COUNT);
      busy         <= (state_next != IDLE);
      all_done     <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_pat    <= '0;
      data        <= '1;
      pat_idx     <= 3'd0;
      nib         <= 3'd0;
      seen_f      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_pat    <= '0;
        data        <= '1;
        pat_idx     <= 3'd0;
        nib         <= 3'd0;
        seen_f      <= 1'b0;
        timeout_err <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
      end

      if (state == FETCH) begin
        // once a terminator nibble is seen, the rest of the slot reads as F
        data[3'(PAT_LEN - 1) - nib] <= seen_f ? 4'hF : spo_pat;
        if (spo_pat == 4'hF) seen_f <= 1'b1;
        if (state_next == FETCH) begin
          nib      <= nib + 3'd1;
          addr_pat <= addr_pat + PAT_AW'(1);
        end
      end

      if ((state == NEXT) && (state_next == FETCH)) begin
        pat_idx  <= pat_idx + 3'd1;
        nib      <= 3'd0;
        seen_f   <= 1'b0;
        addr_pat <= addr_pat + PAT_AW'(1);
      end
    end
  end

  // Watchdog runs only across consecutive COUNT cycles of one pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      wdog <= '0;
    else if ((state == COUNT) && (state_next == COUNT)) wdog <= wdog + WD_W'(1);
    else                                           wdog <= '0;
  end

endmodule

// File: tb/tb_codon_pattern_loader.sv
// Directed bench for codon_pattern_loader: ROM model, hand-sequenced runs,
// and a second instance with a short watchdog for the timeout cases.
module tb_codon_pattern_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            start, abort, done_gen;
  logic [3:0]      spo_pat;
  logic [5:0]      addr_pat;
  logic [5:0][3:0] data;
  logic            init_cnt_ena, count_ena, busy, all_done, timeout_err;
  logic [2:0]      pat_idx, state_dbg;

  logic            start_t, done_gen_t;
  logic [3:0]      spo_pat_t;
  logic [5:0]      addr_pat_t;
  logic [5:0][3:0] data_t;
  logic            init_cnt_ena_t, count_ena_t, busy_t, all_done_t, timeout_err_t;
  logic [2:0]      pat_idx_t, state_dbg_t;

  logic [3:0] rom [0:63];
  assign spo_pat   = rom[addr_pat];
  assign spo_pat_t = rom[addr_pat_t];

  codon_pattern_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .spo_pat(spo_pat),
    .addr_pat(addr_pat), .data(data), .init_cnt_ena(init_cnt_ena),
    .count_ena(count_ena), .done_gen(done_gen), .busy(busy), .pat_idx(pat_idx),
    .all_done(all_done), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  codon_pattern_loader #(.TIMEOUT(16)) u_dut_to (
    .clk(clk), .rst(rst), .start(start_t), .abort(abort), .spo_pat(spo_pat_t),
    .addr_pat(addr_pat_t), .data(data_t), .init_cnt_ena(init_cnt_ena_t),
    .count_ena(count_ena_t), .done_gen(done_gen_t), .busy(busy_t), .pat_idx(pat_idx_t),
    .all_done(all_done_t), .timeout_err(timeout_err_t), .state_dbg(state_dbg_t)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int init_pulses = 0;
  int done_pulses = 0;
  int overlap = 0;
  int last_init_cyc = 0;
  int start_cyc, init_base, done_base;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (init_cnt_ena) begin
      init_pulses++;
      last_init_cyc = cyc;
    end
    if (all_done) done_pulses++;
    if (init_cnt_ena && count_ena) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pat(input int p);
    logic [23:0] res;
    logic        seen;
    logic [3:0]  v;
    res  = '0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      v    = rom[6'(p * 6 + k)];
      res  = {res[19:0], (seen ? 4'hF : v)};
      if (v == 4'hF) seen = 1'b1;
    end
    return res;
  endfunction

  // Entered in FETCH k=0 of pattern p; returns in the NEXT cycle.
  task automatic serve(input int p, input int delay);
    logic [23:0] ep;
    ep = exp_pat(p);
    chk("fetch_idx", 32'(pat_idx), 32'(p));
    for (int k = 0; k < 6; k++) begin
      chk("fetch_addr", 32'(addr_pat), 32'(p * 6 + k));
      chk("fetch_enables", 32'({init_cnt_ena, count_ena}), 32'd0);
      if (k == 2) done_gen = 1'b1;
      tick();
      done_gen = 1'b0;
    end
    chk("init_pulse", 32'(init_cnt_ena), 32'd1);
    chk("init_no_count", 32'(count_ena), 32'd0);
    chk("init_data", 32'(data), 32'(ep));
    chk("init_idx", 32'(pat_idx), 32'(p));
    chk("init_no_done", 32'(all_done), 32'd0);
    tick();
    chk("count_rise", 32'(count_ena), 32'd1);
    chk("count_no_init", 32'(init_cnt_ena), 32'd0);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("count_held", 32'(count_ena), 32'd1);
    end
    done_gen = 1'b1;
    tick();
    done_gen = 1'b0;
    chk("next_count_low", 32'(count_ena), 32'd0);
    chk("next_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; done_gen = 1'b0;
    start_t = 1'b0; done_gen_t = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 4'((i * 7 + 3) % 15);
    rst = 1'b0;
    #1;
    chk("rst_addr", 32'(addr_pat), 32'd0);
    chk("rst_data", 32'(data), 32'hFFFFFF);
    chk("rst_idx", 32'(pat_idx), 32'd0);
    chk("rst_flags", 32'({init_cnt_ena, count_ena, busy, all_done, timeout_err}), 32'd0);
    #20 rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // six valid patterns, done_gen 10 cycles after each count rise
    init_base = init_pulses; done_base = done_pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      serve(p, 10);
      tick();
    end
    chk("done_pulse", 32'(all_done), 32'd1);
    chk("done_idx", 32'(pat_idx), 32'd5);
    tick();
    chk("done_single", 32'(all_done), 32'd0);
    chk("done_idle", 32'(busy), 32'd0);
    chk("six_inits", 32'(init_pulses - init_base), 32'd6);
    chk("one_done", 32'(done_pulses - done_base), 32'd1);

    // terminator inside pattern 0, done_gen 20 cycles after count rise
    rom[0] = 4'h4; rom[1] = 4'h1; rom[2] = 4'h3;
    rom[3] = 4'hF; rom[4] = 4'h2; rom[5] = 4'h2;
    start_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(0, 20);
    chk("trunc_data", 32'(data), 32'h413FFF);
    chk("init_cycle", 32'(last_init_cyc - start_cyc), 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_next_idle", 32'(busy), 32'd0);

    // empty pattern 2 ends the list early
    for (int i = 0; i < 6; i++) rom[i] = 4'((i * 7 + 3) % 15);
    rom[12] = 4'hF;
    init_base = init_pulses; done_base = done_pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(0, 10);
    tick();
    serve(1, 10);
    tick();
    chk("empty_addr", 32'(addr_pat), 32'd12);
    chk("empty_idx", 32'(pat_idx), 32'd2);
    tick();
    chk("empty_done", 32'(all_done), 32'd1);
    chk("empty_no_init", 32'(init_cnt_ena), 32'd0);
    tick();
    chk("empty_hold_idx", 32'(pat_idx), 32'd2);
    chk("empty_idle", 32'(busy), 32'd0);
    chk("empty_two_inits", 32'(init_pulses - init_base), 32'd2);
    chk("empty_one_done", 32'(done_pulses - done_base), 32'd1);
    rom[12] = 4'((12 * 7 + 3) % 15);

    // start held through COUNT, abort in FETCH of pattern 3
    done_base = done_pulses;
    start = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      serve(p, 10);
      tick();
    end
    chk("no_restart_idx", 32'(pat_idx), 32'd3);
    chk("no_restart_addr", 32'(addr_pat), 32'd18);
    tick();
    tick();
    abort = 1'b1;
    start = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_enables", 32'({init_cnt_ena, count_ena}), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_err", 32'(timeout_err), 32'd0);
    tick();
    chk("abort_no_done", 32'(done_pulses - done_base), 32'd0);

    // watchdog instance, TIMEOUT=16
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    repeat (6) tick();
    chk("to_init", 32'(init_cnt_ena_t), 32'd1);
    tick();
    for (int j = 0; j < 16; j++) begin
      chk("to_count_high", 32'(count_ena_t), 32'd1);
      tick();
    end
    chk("to_count_low", 32'(count_ena_t), 32'd0);
    chk("to_err_set", 32'(timeout_err_t), 32'd1);
    chk("to_idle", 32'(busy_t), 32'd0);
    chk("to_no_done", 32'(all_done_t), 32'd0);
    tick();
    chk("to_err_sticky", 32'(timeout_err_t), 32'd1);
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    chk("to_err_cleared", 32'(timeout_err_t), 32'd0);
    chk("to_busy", 32'(busy_t), 32'd1);
    repeat (6) tick();
    tick();
    repeat (15) tick();
    done_gen_t = 1'b1;
    tick();
    done_gen_t = 1'b0;
    chk("to_tie_no_err", 32'(timeout_err_t), 32'd0);
    chk("to_tie_next", 32'({busy_t, count_ena_t}), 32'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("to_abort_idle", 32'(busy_t), 32'd0);

    // asynchronous reset in the middle of FETCH
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(addr_pat), 32'd0);
    chk("mid_rst_data", 32'(data), 32'hFFFFFF);
    chk("mid_rst_idx", 32'(pat_idx), 32'd0);
    chk("mid_rst_flags", 32'({init_cnt_ena, count_ena, busy, all_done, timeout_err}), 32'd0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    chk("never_both_enables", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
